lnrv_icb_arbiter: RTL and testbench
===================================

LNRV_ICB_ARBITER -- requirements
Module: lnrv_icb_arbiter

Interface
REQ-001 SHALL have parameter P_MASTERS, default 2, number of ICB requesters (2..4).
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 32, command address width.
REQ-003 SHALL have parameter P_DATA_WIDTH, default 32, data width; strobe width is P_DATA_WIDTH/8.
REQ-004 SHALL have parameter P_OUTS, default 4, maximum outstanding commands (power of 2, 1..8).
REQ-005 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports m_icb_cmd_vld/rdy/write, in/out/in, P_MASTERS each, per-master command handshake and direction.
REQ-008 SHALL have ports m_icb_cmd_addr/wdata/wstrb, input, P_MASTERS x field width, flattened with master i at slice i.
REQ-009 SHALL have ports m_icb_rsp_vld/rdy/err, out/in/out, P_MASTERS each, and m_icb_rsp_rdata, output, P_MASTERS x P_DATA_WIDTH.
REQ-010 SHALL have ports s_icb_cmd_vld/rdy/write/addr/wdata/wstrb and s_icb_rsp_vld/rdy/err/rdata toward the single shared slave, standard ICB directions and widths.

Function
REQ-011 SHALL raise s_icb_cmd_vld when at least one master requests and the route FIFO is not full; all payload comes from the granted master, with no added latency.
REQ-012 SHALL drive m_icb_cmd_rdy[i] = s_icb_cmd_rdy & grant[i] & ~full; all other masters see rdy low.
REQ-013 SHALL lock the grant once s_icb_cmd_vld is high and no handshake has occurred, so the granted master and payload stay stable until s_icb_cmd_vld & s_icb_cmd_rdy.
REQ-014 SHALL, on each command handshake, push the granted master index into a P_OUTS-deep route FIFO.
REQ-015 SHALL route s_icb_rsp_vld, err, and rdata only to the master at the FIFO head; all other m_icb_rsp_vld bits are 0, and their rdata is don't-care.
REQ-016 SHALL drive s_icb_rsp_rdy = m_icb_rsp_rdy[head] when the FIFO is non-empty, else 0; it SHALL pop on a response handshake.
REQ-017 SHALL compute full from the registered count only: a pop in the same cycle does not unblock a push while full.
REQ-018 SHALL allow a push and pop in the same cycle when not full; the count is then unchanged.
REQ-019 SHALL implement wrap-around of read and write pointers modulo P_OUTS, with the count width covering 0..P_OUTS.
REQ-020 SHALL ignore s_icb_rsp_vld when the FIFO is empty, hold rsp_rdy low, and forward nothing.
REQ-021 SHALL update the round-robin pointer only on a command handshake, setting it to (winner+1) mod P_MASTERS.

Reset
REQ-022 SHALL, while reset_n is low, clear the FIFO pointers and count, the round-robin pointer (to 0), and the grant lock.
REQ-023 SHALL, on reset mid-transaction, drop all outstanding routing; outputs reset to s_icb_cmd_vld=0 (absent requests), s_icb_rsp_rdy=0, and m_icb_rsp_vld=0, with all m_icb_cmd_rdy=0.

Configuration
REQ-024 SHALL, with macro LNRV_ICB_ARB_RR_EN defined, use round-robin arbitration starting search at the round-robin pointer.
REQ-025 SHALL, without LNRV_ICB_ARB_RR_EN, use fixed priority (lowest index wins), with the round-robin pointer not implemented; REQ-013 lock still applies.

Verification
REQ-026 SHALL cover the following case: masters 0 and 1 request continuously, slave rdy=1, with RR_EN defined -> grants alternate 0,1,0,1 (without RR_EN, grants are all 0).
REQ-027 SHALL cover the following case: master 1 is granted, slave rdy=0 for 3 cycles, and master 0 asserts meanwhile -> the grant stays on 1, and addr is stable until the handshake.
REQ-028 SHALL cover the following case: P_OUTS=4, 4 commands accepted with no responses -> s_icb_cmd_vld=0 and all cmd_rdy=0; the 5th command is accepted the cycle after the first response pops.
REQ-029 SHALL cover the following case: commands issued in order m0,m1,m0 with responses rdata 0xA,0xB,0xC -> m0 receives 0xA then 0xC, and m1 receives 0xB, with err routed alike.
REQ-030 SHALL cover the following case: head master holds rsp_rdy=0 for 2 cycles -> s_icb_rsp_rdy=0 for those cycles, and no pop occurs.
REQ-031 SHALL cover the following case: reset_n is pulsed low with 2 outstanding commands -> count=0, s_icb_rsp_rdy=0, and the next grant comes from master 0.

Source files
------------

// File: rtl/lnrv_icb_arbiter.sv
// rtl/lnrv_icb_arbiter.sv - N:1 ICB arbiter with in-order response routing FIFO
// Optional round-robin arbitration: define LNRV_ICB_ARB_RR_EN (default build is fixed priority).
module lnrv_icb_arbiter #(
  parameter int P_MASTERS    = 2,
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_OUTS       = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [P_MASTERS-1:0]                   m_icb_cmd_vld,
  output logic [P_MASTERS-1:0]                   m_icb_cmd_rdy,
  input  logic [P_MASTERS-1:0]                   m_icb_cmd_write,
  input  logic [P_MASTERS*P_ADDR_WIDTH-1:0]      m_icb_cmd_addr,
  input  logic [P_MASTERS*P_DATA_WIDTH-1:0]      m_icb_cmd_wdata,
  input  logic [P_MASTERS*(P_DATA_WIDTH/8)-1:0]  m_icb_cmd_wstrb,
  output logic [P_MASTERS-1:0]                   m_icb_rsp_vld,
  input  logic [P_MASTERS-1:0]                   m_icb_rsp_rdy,
  output logic [P_MASTERS-1:0]                   m_icb_rsp_err,
  output logic [P_MASTERS*P_DATA_WIDTH-1:0]      m_icb_rsp_rdata,
  output logic                                   s_icb_cmd_vld,
  input  logic                                   s_icb_cmd_rdy,
  output logic                                   s_icb_cmd_write,
  output logic [P_ADDR_WIDTH-1:0]                s_icb_cmd_addr,
  output logic [P_DATA_WIDTH-1:0]                s_icb_cmd_wdata,
  output logic [P_DATA_WIDTH/8-1:0]              s_icb_cmd_wstrb,
  input  logic                                   s_icb_rsp_vld,
  output logic                                   s_icb_rsp_rdy,
  input  logic                                   s_icb_rsp_err,
  input  logic [P_DATA_WIDTH-1:0]                s_icb_rsp_rdata
);
  localparam int SW = P_DATA_WIDTH / 8;
  localparam int MW = (P_MASTERS > 1) ? $clog2(P_MASTERS) : 1;
  localparam int PW = (P_OUTS > 1) ? $clog2(P_OUTS) : 1;
  localparam int CW = $clog2(P_OUTS + 1);

  logic [MW-1:0] route_q [P_OUTS];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [MW-1:0] lock_idx_q, lock_idx_d;
  logic [MW-1:0] win_idx, grant_idx, head;
  logic          win_found, grant_vld, full, empty, push, pop;

`ifdef LNRV_ICB_ARB_RR_EN
  logic [MW-1:0] rr_q, rr_d;
`endif

  // Search order starts at the rotating pointer (RR) or at master 0 (fixed priority).
  always_comb begin : arb
    int            tmp;
    logic [MW-1:0] idx;
    win_idx   = '0;
    win_found = 1'b0;
    tmp       = 0;
    idx       = '0;
    for (int k = 0; k < P_MASTERS; k++) begin
`ifdef LNRV_ICB_ARB_RR_EN
      tmp = int'(rr_q) + k;
      if (tmp >= P_MASTERS) tmp = tmp - P_MASTERS;
`else
      tmp = k;
`endif
      idx = MW'(tmp);
      if (!win_found && m_icb_cmd_vld[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign grant_vld = lock_q | win_found;
  assign grant_idx = lock_q ? lock_idx_q : win_idx;
  assign full      = (cnt_q == CW'(P_OUTS));
  assign empty     = (cnt_q == '0);
  assign head      = route_q[rd_ptr_q];

  assign s_icb_cmd_vld   = grant_vld & m_icb_cmd_vld[grant_idx] & ~full;
  assign s_icb_rsp_rdy   = ~empty & m_icb_rsp_rdy[head];
  assign m_icb_rsp_rdata = {P_MASTERS{s_icb_rsp_rdata}};
  assign push            = s_icb_cmd_vld & s_icb_cmd_rdy;
  assign pop             = s_icb_rsp_vld & s_icb_rsp_rdy;

  always_comb begin
    s_icb_cmd_write = 1'b0;
    s_icb_cmd_addr  = '0;
    s_icb_cmd_wdata = '0;
    s_icb_cmd_wstrb = '0;
    m_icb_cmd_rdy   = '0;
    m_icb_rsp_vld   = '0;
    m_icb_rsp_err   = '0;
    for (int i = 0; i < P_MASTERS; i++) begin
      if (grant_idx == MW'(i)) begin
        s_icb_cmd_write  = m_icb_cmd_write[i];
        s_icb_cmd_addr   = m_icb_cmd_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        s_icb_cmd_wdata  = m_icb_cmd_wdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        s_icb_cmd_wstrb  = m_icb_cmd_wstrb[i*SW +: SW];
        m_icb_cmd_rdy[i] = s_icb_cmd_rdy & grant_vld & ~full;
      end
      if (!empty && head == MW'(i)) begin
        m_icb_rsp_vld[i] = s_icb_rsp_vld;
        m_icb_rsp_err[i] = s_icb_rsp_vld & s_icb_rsp_err;
      end
    end
  end

  // An offered but unaccepted command pins the grant until its handshake.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    lock_d     = s_icb_cmd_vld & ~s_icb_cmd_rdy;
    lock_idx_d = grant_idx;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(P_OUTS - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(P_OUTS - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef LNRV_ICB_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (grant_idx == MW'(P_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`ifdef LNRV_ICB_ARB_RR_EN
      rr_q       <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`ifdef LNRV_ICB_ARB_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) route_q[wr_ptr_q] <= grant_idx;
  end

endmodule

// File: tb/tb_lnrv_icb_arbiter.sv
// tb/tb_lnrv_icb_arbiter.sv - directed and random bench for lnrv_icb_arbiter
// Expectations come from a queue-based model of the arbitration and routing rules.
module tb_lnrv_icb_arbiter;
  localparam int M    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int OUTS = 4;

  logic            clk, reset_n;
  logic [M-1:0]    m_icb_cmd_vld, m_icb_cmd_rdy, m_icb_cmd_write;
  logic [M*AW-1:0] m_icb_cmd_addr;
  logic [M*DW-1:0] m_icb_cmd_wdata;
  logic [M*SW-1:0] m_icb_cmd_wstrb;
  logic [M-1:0]    m_icb_rsp_vld, m_icb_rsp_rdy, m_icb_rsp_err;
  logic [M*DW-1:0] m_icb_rsp_rdata;
  logic            s_icb_cmd_vld, s_icb_cmd_rdy, s_icb_cmd_write;
  logic [AW-1:0]   s_icb_cmd_addr;
  logic [DW-1:0]   s_icb_cmd_wdata;
  logic [SW-1:0]   s_icb_cmd_wstrb;
  logic            s_icb_rsp_vld, s_icb_rsp_rdy, s_icb_rsp_err;
  logic [DW-1:0]   s_icb_rsp_rdata;

  lnrv_icb_arbiter #(.P_MASTERS(M), .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_OUTS(OUTS)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_icb_cmd_vld(m_icb_cmd_vld), .m_icb_cmd_rdy(m_icb_cmd_rdy), .m_icb_cmd_write(m_icb_cmd_write),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wstrb(m_icb_cmd_wstrb),
    .m_icb_rsp_vld(m_icb_rsp_vld), .m_icb_rsp_rdy(m_icb_rsp_rdy), .m_icb_rsp_err(m_icb_rsp_err),
    .m_icb_rsp_rdata(m_icb_rsp_rdata),
    .s_icb_cmd_vld(s_icb_cmd_vld), .s_icb_cmd_rdy(s_icb_cmd_rdy), .s_icb_cmd_write(s_icb_cmd_write),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wstrb(s_icb_cmd_wstrb),
    .s_icb_rsp_vld(s_icb_rsp_vld), .s_icb_rsp_rdy(s_icb_rsp_rdy), .s_icb_rsp_err(s_icb_rsp_err),
    .s_icb_rsp_rdata(s_icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           route[$];
  int           rr, lock_m, n_cmp, n_err, n_acc, obs_win, obs_rsp_m;
  bit           lock;
  int           exp_alt[4];
  logic         obs_svld, obs_srsp_rdy, obs_rerr;
  logic [M-1:0] obs_cmd_rdy;
  logic [31:0]  obs_addr, obs_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int m;
    for (int k = 0; k < M; k++) begin
`ifdef LNRV_ICB_ARB_RR_EN
      m = (rr + k) % M;
`else
      m = k;
`endif
      if (m_icb_cmd_vld[m]) return m;
    end
    return -1;
  endfunction

  task automatic req(input int m, input logic [31:0] a);
    m_icb_cmd_vld[m]             = 1'b1;
    m_icb_cmd_addr[m*AW +: AW]   = a;
    m_icb_cmd_wdata[m*DW +: DW]  = $urandom;
    m_icb_cmd_wstrb[m*SW +: SW]  = SW'($urandom);
    m_icb_cmd_write[m]           = 1'($urandom);
  endtask

  // One clock: check every output against the model, then advance model and DUT together.
  task automatic cycle();
    int           win, head;
    bit           full, push, pop;
    logic [M-1:0] exp_rdy, exp_rv, exp_re;
    #1;
    full = (route.size() == OUTS);
    win  = -1;
    if (!full) win = lock ? lock_m : pick();
    obs_svld = s_icb_cmd_vld; obs_addr = s_icb_cmd_addr;
    obs_srsp_rdy = s_icb_rsp_rdy; obs_cmd_rdy = m_icb_cmd_rdy;
    obs_win = -1; obs_rsp_m = -1; obs_rdata = '0; obs_rerr = 1'b0;
    for (int m = 0; m < M; m++) begin
      if (m_icb_cmd_vld[m] && m_icb_cmd_rdy[m]) obs_win = m;
      if (m_icb_rsp_vld[m]) begin
        obs_rsp_m = m; obs_rdata = m_icb_rsp_rdata[m*DW +: DW]; obs_rerr = m_icb_rsp_err[m];
      end
    end
    exp_rdy = '0;
    if (win >= 0 && s_icb_cmd_rdy) exp_rdy[win] = 1'b1;
    check("s_cmd_vld", s_icb_cmd_vld, win >= 0);
    check("m_cmd_rdy", m_icb_cmd_rdy, exp_rdy);
    if (win >= 0) begin
      check("s_cmd_addr", s_icb_cmd_addr, m_icb_cmd_addr[win*AW +: AW]);
      check("s_cmd_wdata", s_icb_cmd_wdata, m_icb_cmd_wdata[win*DW +: DW]);
      check("s_cmd_wstrb", s_icb_cmd_wstrb, m_icb_cmd_wstrb[win*SW +: SW]);
      check("s_cmd_write", s_icb_cmd_write, m_icb_cmd_write[win]);
    end
    head = (route.size() > 0) ? route[0] : -1;
    exp_rv = '0; exp_re = '0;
    if (head >= 0 && s_icb_rsp_vld) begin exp_rv[head] = 1'b1; exp_re[head] = s_icb_rsp_err; end
    check("m_rsp_vld", m_icb_rsp_vld, exp_rv);
    check("m_rsp_err", m_icb_rsp_err, exp_re);
    check("s_rsp_rdy", s_icb_rsp_rdy, (head >= 0) ? m_icb_rsp_rdy[head] : 1'b0);
    if (head >= 0 && s_icb_rsp_vld) check("m_rsp_rdata", m_icb_rsp_rdata[head*DW +: DW], s_icb_rsp_rdata);
    push = (win >= 0) && s_icb_cmd_rdy;
    pop  = (head >= 0) && s_icb_rsp_vld && m_icb_rsp_rdy[head];
    if (pop) route.delete(0);
    if (push) begin route.push_back(win); rr = (win + 1) % M; end
    lock   = (win >= 0) && !s_icb_cmd_rdy;
    lock_m = win;
    @(posedge clk);
    #1;
    if (push) m_icb_cmd_vld[win] = 1'b0;
  endtask

  task automatic settle();
    s_icb_cmd_rdy = 1'b1; s_icb_rsp_vld = 1'b1; m_icb_rsp_rdy = '1;
    for (int i = 0; i < 30; i++) if (m_icb_cmd_vld != '0 || route.size() != 0) cycle();
    s_icb_rsp_vld = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; rr = 0; lock = 1'b0; lock_m = -1; n_acc = 0;
`ifdef LNRV_ICB_ARB_RR_EN
    exp_alt = '{0, 1, 0, 1};
`else
    exp_alt = '{0, 0, 0, 0};
`endif
    reset_n = 1'b0;
    m_icb_cmd_vld = '0; m_icb_cmd_write = '0; m_icb_cmd_addr = '0; m_icb_cmd_wdata = '0;
    m_icb_cmd_wstrb = '0; m_icb_rsp_rdy = '1; s_icb_cmd_rdy = 1'b1;
    s_icb_rsp_vld = 1'b1; s_icb_rsp_err = 1'b0; s_icb_rsp_rdata = 32'h5A5A;
    cycle();
    check("rst_s_cmd_vld", obs_svld, 1'b0);
    check("rst_s_rsp_rdy", obs_srsp_rdy, 1'b0);
    reset_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      if (!m_icb_cmd_vld[0]) req(0, 32'h100 + 32'(k));
      if (!m_icb_cmd_vld[1]) req(1, 32'h200 + 32'(k));
      cycle();
      check("alt_grant", obs_win, exp_alt[k]);
    end
    settle();

    s_icb_cmd_rdy = 1'b0;
    req(1, 32'h1111);
    cycle();
    check("lock_addr", obs_addr, 32'h1111);
    req(0, 32'h0A0A);
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("lock_addr_hold", obs_addr, 32'h1111);
    end
    s_icb_cmd_rdy = 1'b1;
    cycle();
    check("lock_grant", obs_win, 1);
    cycle();
    check("after_lock_grant", obs_win, 0);
    settle();

    s_icb_rsp_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req(k % 2, 32'h3000 + 32'(k));
      cycle();
      if (obs_win >= 0) n_acc++;
    end
    check("fill_accepts", n_acc, 4);
    req(2, 32'h3333);
    cycle();
    check("full_s_cmd_vld", obs_svld, 1'b0);
    check("full_cmd_rdy", obs_cmd_rdy, '0);
    s_icb_rsp_vld = 1'b1;
    cycle();
    check("full_pop_no_push", obs_win, -1);
    s_icb_rsp_vld = 1'b0;
    cycle();
    check("fifth_accept", obs_win, 2);
    settle();

    req(0, 32'h40); cycle();
    req(1, 32'h41); cycle();
    req(0, 32'h42); cycle();
    s_icb_rsp_vld = 1'b1;
    s_icb_rsp_rdata = 32'hA; s_icb_rsp_err = 1'b0; cycle();
    check("rsp_a_master", obs_rsp_m, 0); check("rsp_a_data", obs_rdata, 32'hA);
    s_icb_rsp_rdata = 32'hB; s_icb_rsp_err = 1'b1; cycle();
    check("rsp_b_master", obs_rsp_m, 1); check("rsp_b_data", obs_rdata, 32'hB);
    check("rsp_b_err", obs_rerr, 1'b1);
    s_icb_rsp_rdata = 32'hC; s_icb_rsp_err = 1'b0; cycle();
    check("rsp_c_master", obs_rsp_m, 0); check("rsp_c_data", obs_rdata, 32'hC);
    s_icb_rsp_vld = 1'b0;

    req(1, 32'h50); cycle();
    s_icb_rsp_vld = 1'b1; s_icb_rsp_rdata = 32'hD; m_icb_rsp_rdy = 3'b101;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("stall_rsp_rdy", obs_srsp_rdy, 1'b0);
    end
    m_icb_rsp_rdy = '1;
    cycle();
    check("stall_release_rdy", obs_srsp_rdy, 1'b1);
    check("stall_release_m", obs_rsp_m, 1);
    s_icb_rsp_vld = 1'b0;

    req(1, 32'h60); cycle();
    req(0, 32'h61); cycle();
    reset_n = 1'b0; route.delete(); rr = 0; lock = 1'b0;
    s_icb_rsp_vld = 1'b1;
    cycle();
    check("mid_rst_rsp_rdy", obs_srsp_rdy, 1'b0);
    check("mid_rst_rsp_m", obs_rsp_m, -1);
    reset_n = 1'b1;
    req(0, 32'h70); req(1, 32'h71);
    cycle();
    check("post_rst_grant", obs_win, 0);
    check("empty_rsp_ignored", obs_rsp_m, -1);
    settle();

    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < M; m++) if (!m_icb_cmd_vld[m] && ($urandom % 3 == 0)) req(m, $urandom);
      s_icb_cmd_rdy   = ($urandom % 4) != 0;
      s_icb_rsp_vld   = 1'($urandom);
      s_icb_rsp_err   = 1'($urandom);
      s_icb_rsp_rdata = $urandom;
      m_icb_rsp_rdy   = M'($urandom);
      cycle();
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
